// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 controller: opcodes, sequencer states and the
// control-word layout used by both the sequencer and the datapath top.
package sap_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_e;

  // Field names keep the physical polarity of each bus line (n_* = active low).
  typedef struct packed {
    logic cp;
    logic ep;
    logic n_lm;
    logic n_ce;
    logic ir_clear;
    logic n_li;
    logic n_ei;
    logic n_la;
    logic ea;
    logic su;
    logic eu;
    logic n_lb;
    logic n_lo;
  } ctrl_word_t;

  localparam ctrl_word_t CW_IDLE = '{
    cp: 1'b0, ep: 1'b0, n_lm: 1'b1, n_ce: 1'b1, ir_clear: 1'b0, n_li: 1'b1,
    n_ei: 1'b1, n_la: 1'b1, ea: 1'b0, su: 1'b0, eu: 1'b0, n_lb: 1'b1, n_lo: 1'b1
  };

  localparam ctrl_word_t CW_RESET = '{
    cp: 1'b0, ep: 1'b0, n_lm: 1'b1, n_ce: 1'b1, ir_clear: 1'b1, n_li: 1'b1,
    n_ei: 1'b1, n_la: 1'b1, ea: 1'b0, su: 1'b0, eu: 1'b0, n_lb: 1'b1, n_lo: 1'b1
  };

  // Instructions that fetch an operand from memory during T4/T5.
  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// Six-state T-ring with run gating and a HALT trap that only reset releases.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       is_hlt_i,
  output state_e     state_o,
  output logic [5:0] t_state_o,
  output logic       halted_o
);

  state_e state_q;

  // The RST exit is unconditional so the machine always reaches T1 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
    end else begin
      case (state_q)
        S_RST:  state_q <= S_T1;
        S_T1:   if (run_i) state_q <= S_T2;
        S_T2:   if (run_i) state_q <= S_T3;
        S_T3:   if (run_i) state_q <= S_T4;
        S_T4:   if (run_i) state_q <= is_hlt_i ? S_HALT : S_T5;
        S_T5:   if (run_i) state_q <= S_T6;
        S_T6:   if (run_i) state_q <= S_T1;
        default: state_q <= S_HALT;
      endcase
    end
  end

  always_comb begin
    t_state_o = 6'b000000;
    case (state_q)
      S_T1:    t_state_o = 6'b000001;
      S_T2:    t_state_o = 6'b000010;
      S_T3:    t_state_o = 6'b000100;
      S_T4:    t_state_o = 6'b001000;
      S_T5:    t_state_o = 6'b010000;
      S_T6:    t_state_o = 6'b100000;
      default: t_state_o = 6'b000000;
    endcase
  end

  assign state_o  = state_q;
  assign halted_o = (state_q == S_HALT);

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 control unit: steps the T-ring and decodes state plus opcode into the
// bus control word.
module sap_controller_sequencer
  import sap_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [5:0]          t_state,
  output logic                halted,
  output logic                cp,
  output logic                ep,
  output logic                n_lm,
  output logic                n_ce,
  output logic                ir_clear,
  output logic                n_li,
  output logic                n_ei,
  output logic                n_la,
  output logic                ea,
  output logic                su,
  output logic                eu,
  output logic                n_lb,
  output logic                n_lo
);

  state_e     state;
  ctrl_word_t cw;

  sap_ring_counter u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (run),
    .is_hlt_i  (opcode == OP_HLT),
    .state_o   (state),
    .t_state_o (t_state),
    .halted_o  (halted)
  );

  // Opcode only matters from T4 on; the IR is not valid before then.
  always_comb begin
    cw = CW_IDLE;
    case (state)
      S_RST: cw = CW_RESET;
      S_T1: begin
        cw.ep   = 1'b1;
        cw.n_lm = 1'b0;
      end
      S_T2: cw.cp = 1'b1;
      S_T3: begin
        cw.n_ce = 1'b0;
        cw.n_li = 1'b0;
      end
      S_T4: begin
        if (is_mem_op(opcode)) begin
          cw.n_ei = 1'b0;
          cw.n_lm = 1'b0;
        end else if (opcode == OP_OUT) begin
          cw.ea   = 1'b1;
          cw.n_lo = 1'b0;
        end
      end
      S_T5: begin
        if (opcode == OP_LDA) begin
          cw.n_ce = 1'b0;
          cw.n_la = 1'b0;
        end else if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw.n_ce = 1'b0;
          cw.n_lb = 1'b0;
        end
      end
      S_T6: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw.eu   = 1'b1;
          cw.su   = (opcode == OP_SUB);
          cw.n_la = 1'b0;
        end
      end
      default: cw = CW_IDLE;
    endcase
  end

  assign cp       = cw.cp;
  assign ep       = cw.ep;
  assign n_lm     = cw.n_lm;
  assign n_ce     = cw.n_ce;
  assign ir_clear = cw.ir_clear;
  assign n_li     = cw.n_li;
  assign n_ei     = cw.n_ei;
  assign n_la     = cw.n_la;
  assign ea       = cw.ea;
  assign su       = cw.su;
  assign eu       = cw.eu;
  assign n_lb     = cw.n_lb;
  assign n_lo     = cw.n_lo;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Randomized bench for the SAP-1 controller against a phase-number reference model.
module tb_sap_controller_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic       halted, cp, ep, n_lm, n_ce, ir_clear, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo;

  int tests_run = 0;
  int tests_failed = 0;
  int ph = 0; // model phase: 0 = reset, 1..6 = T1..T6, 7 = halted

  sap_controller_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .t_state(t_state), .halted(halted), .cp(cp), .ep(ep), .n_lm(n_lm),
    .n_ce(n_ce), .ir_clear(ir_clear), .n_li(n_li), .n_ei(n_ei), .n_la(n_la),
    .ea(ea), .su(su), .eu(eu), .n_lb(n_lb), .n_lo(n_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asserted-line bit positions (before polarity is applied).
  localparam int A_CP = 12, A_EP = 11, A_LM = 10, A_CE = 9, A_IRC = 8, A_LI = 7,
                 A_EI = 6, A_LA = 5, A_EA = 4, A_SU = 3, A_EU = 2, A_LB = 1, A_LO = 0;
  localparam logic [12:0] ACTIVE_LOW = 13'b0_0110_1110_0011;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (phase %0d, opcode %h, t=%0t)",
               tag, obs, exp, ph, opcode, $time);
    end
  endtask

  // Expected {t_state, halted, control lines} straight from the state/opcode table.
  function automatic logic [19:0] model_out(input int p, input logic [3:0] op);
    logic [12:0] a;
    logic [5:0]  ts;
    a  = '0;
    ts = (p >= 1 && p <= 6) ? 6'(1 << (p - 1)) : 6'd0;
    case (p)
      0: a[A_IRC] = 1'b1;
      1: begin a[A_EP] = 1'b1; a[A_LM] = 1'b1; end
      2: a[A_CP] = 1'b1;
      3: begin a[A_CE] = 1'b1; a[A_LI] = 1'b1; end
      4: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin a[A_EI] = 1'b1; a[A_LM] = 1'b1; end
        if (op == 4'hE) begin a[A_EA] = 1'b1; a[A_LO] = 1'b1; end
      end
      5: begin
        if (op == 4'h0) begin a[A_CE] = 1'b1; a[A_LA] = 1'b1; end
        if (op == 4'h1 || op == 4'h2) begin a[A_CE] = 1'b1; a[A_LB] = 1'b1; end
      end
      6: if (op == 4'h1 || op == 4'h2) begin
        a[A_EU] = 1'b1; a[A_LA] = 1'b1; a[A_SU] = (op == 4'h2);
      end
      default: ;
    endcase
    return {ts, (p == 7), a ^ ACTIVE_LOW};
  endfunction

  task automatic check_now(input string tag);
    logic [4:0] drivers;
    check(tag, {12'd0, t_state, halted, cp, ep, n_lm, n_ce, ir_clear, n_li, n_ei,
                n_la, ea, su, eu, n_lb, n_lo}, {12'd0, model_out(ph, opcode)});
    drivers = {ep, ~n_ce, ~n_ei, ea, eu};
    check("bus_excl", 32'($countones(drivers) <= 1), 32'd1);
  endtask

  // Called at a negedge: drive inputs, check, take one clock, leave at next negedge.
  task automatic step(input string tag, input logic r, input logic [3:0] op);
    run = r;
    opcode = op;
    #1;
    check_now(tag);
    @(posedge clk);
    if (ph == 0) ph = 1;
    else if (ph != 7 && r) ph = (ph == 4 && op == 4'hF) ? 7 : (ph % 6) + 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ph = 0;
    #1;
    check_now("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to(input int target, input logic [3:0] op);
    for (int i = 0; i < 20 && ph != target; i++) step("advance", 1'b1, op);
    if (ph != target) begin
      $display("FAIL run_to: phase %0d required %0d", ph, target);
      $fatal(1, "sequencer model did not reach target phase");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b1;
    opcode = 4'h0;
    #3;
    check_now("reset_async");
    @(negedge clk);
    do_reset();

    // ADD then SUB then OUT then LDA, each held through a full instruction.
    for (int i = 0; i < 7; i++) step("add", 1'b1, 4'h1);
    for (int i = 0; i < 6; i++) step("sub", 1'b1, 4'h2);
    for (int i = 0; i < 6; i++) step("out", 1'b1, 4'hE);
    for (int i = 0; i < 6; i++) step("lda", 1'b1, 4'h0);

    // Pause in T3 for five cycles, then resume.
    run_to(3, 4'h0);
    for (int i = 0; i < 5; i++) step("pause_t3", 1'b0, 4'($urandom_range(0, 15)));
    step("resume_t3", 1'b1, 4'h0);
    step("resume_t4", 1'b1, 4'h0);

    // HLT traps until reset, whatever run does.
    run_to(4, 4'hF);
    step("hlt_t4", 1'b1, 4'hF);
    for (int i = 0; i < 20; i++) step("halted", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    do_reset();
    step("post_halt_rst", 1'b1, 4'h0);
    step("post_halt_t1", 1'b1, 4'h0);

    // Reset dropped between edges in T5 of LDA.
    run_to(5, 4'h0);
    #1;
    check_now("lda_t5");
    #1;
    rst_n = 1'b0;
    ph = 0;
    #1;
    check_now("mid_t5_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("after_mid_rst", 1'b1, 4'h0);

    // Random run/opcode traffic with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      if (ph == 7 || $urandom_range(0, 99) == 0) do_reset();
      step("random", 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
